mux_src_arbiter: RTL and testbench
==================================

// Module: mux_src_arbiter
// PURPOSE
//  Round-robin arbiter that shares the 8-bit 3-source mux (mux_custom) among three requesters.
//  Drives the mux select and returns a one-hot grant to each requester, with a break-before-make gap.
//  Sits between the source blocks (req/grant) and the mux sel input; the mux output feeds the shared sink.
// PARAMETERS
//  SWITCH_GAP  1   dead cycles between owners (legal 1..3); sel is stable and no grant is asserted
//  MAX_HOLD    16  max consecutive GRANT cycles before forced release (used only with MUX_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  req        in   3  request per source; bit0 = src1, bit1 = src2, bit2 = src3; level, held while using bus
//  grant      out  3  one-hot grant, same bit mapping; all-zero when idle or switching
//  sel        out  2  mux select: 2'd1 = src1, 2'd2 = src2, 2'd3 = src3, 2'd0 = park (mux passes src3)
//  out_valid  out  1  high when the mux output carries the granted source (== |grant)
//  busy       out  1  high in SWITCH or GRANT state
//  preempt    out  1  1-cycle pulse on forced release (tied 0 when MUX_ARB_TIMEOUT_EN is undefined)
// BEHAVIOUR
//  Reset: state = IDLE, grant = 3'b000, sel = 2'd0, out_valid = 0, busy = 0, preempt = 0,
//   last_owner = src3, so src1 has highest priority after reset.
//  FSM states: IDLE, SWITCH, GRANT (registered; all outputs registered).
//  IDLE: sel = 2'd0.
//   If any req: pick the first requester after last_owner, cyclic order 1->2->3->1.
//   Load sel = its code and gap_cnt = SWITCH_GAP-1, then go to SWITCH.
//  SWITCH: grant = 0, sel = new owner's code.
//   When gap_cnt == 0 and req[owner] is still high: go to GRANT and set grant[owner] = 1.
//   If req[owner] dropped during SWITCH: re-pick from the remaining reqs (restart gap), or go to IDLE if none.
//  Latency: req rises at edge N with bus idle -> sel valid after N+1 -> grant/out_valid after N+1+SWITCH_GAP.
//  GRANT: grant and sel held constant; hold_cnt increments (saturating).
//   When req[owner] falls, grant drops on the next edge and last_owner = owner.
//   Then: other reqs pending -> pick next (RR) and go to SWITCH; none pending -> IDLE (sel = 2'd0).
//  A release and a new request in the same cycle are handled as pending; the releasing owner is never re-picked if another req is high.
//  Single requester: after release and re-request it goes through SWITCH again (no back-to-back grant without a gap).
//  grant is never multi-hot. sel never changes while grant != 0.
//  hold_cnt is $clog2(MAX_HOLD+1) bits wide, cleared on entry to GRANT.
//  Reset asserted in any state returns everything to reset values on the next edge; an in-flight grant is dropped.
// CONFIGURATION
//  MUX_ARB_TIMEOUT_EN defined:
//   In GRANT, if hold_cnt == MAX_HOLD-1 and another req is high, the owner is forced out:
//   grant drops, preempt pulses for 1 cycle, last_owner = owner, next RR owner goes to SWITCH.
//   With no competitor, the owner keeps the bus indefinitely.
//  Undefined: no preemption; hold_cnt logic is removed; preempt is tied 0.
// STRUCTURE
//  mux_arb_pkg: state encodings (ST_IDLE/ST_SWITCH/ST_GRANT), sel codes (SEL_PARK = 2'd0, SEL_SRC1..SEL_SRC3),
//   NUM_SRC = 3, and a function mapping a one-hot grant to its sel code.
//  Sub-module rr_pick3 (combinational): inputs req[2:0] and last_owner; outputs next one-hot owner and found flag.
//  Top module: FSM, gap/hold counters, output registers.
// TESTING
//  1 Reset, then req = 3'b001 at cycle 0 -> sel = 1 at cycle 1; grant = 001 and out_valid = 1 at cycle 2 (SWITCH_GAP = 1).
//  2 req = 3'b111 from reset, each owner releases after 4 GRANT cycles -> grant order 001,010,100,001.
//    Exactly one zero-grant gap cycle between owners.
//  3 Owner src2 releases while src1 and src3 request -> next owner is src3 (RR after 2), sel = 3.
//  4 src1 drops req during SWITCH while src2 requests -> SWITCH re-picks src2, sel = 2; src1 is never granted.
//  5 Assert rst during GRANT of src3 -> next edge grant = 0, sel = 0, busy = 0.
//    Then req = 111 -> src1 is granted first.
//  6 MUX_ARB_TIMEOUT_EN, MAX_HOLD = 16, src1 holds, src2 requests -> after 16 GRANT cycles grant drops.
//    preempt pulses once, then src2 is granted. Repeat with no competitor -> no preempt.
//  All tests: assertions that grant is one-hot0, that sel is stable while grant != 0, and that out_valid == |grant.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and select codes for the three-source mux arbiter.
package mux_arb_pkg;

  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_GRANT  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_PARK = 2'd0;
  localparam logic [1:0] SEL_SRC1 = 2'd1;
  localparam logic [1:0] SEL_SRC2 = 2'd2;
  localparam logic [1:0] SEL_SRC3 = 2'd3;

  function automatic logic [1:0] sel_of(input logic [NUM_SRC-1:0] oh);
    case (oh)
      3'b001:  return SEL_SRC1;
      3'b010:  return SEL_SRC2;
      3'b100:  return SEL_SRC3;
      default: return SEL_PARK;
    endcase
  endfunction

endpackage

// File: rtl/mux_src_arbiter_rr_pick3.sv
// Round-robin pick among three requesters, starting after last_owner (one-hot).
module rr_pick3
  import mux_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] last_owner,
  output logic [NUM_SRC-1:0] next_owner,
  output logic               found
);

  always_comb begin
    next_owner = '0;
    case (last_owner)
      3'b001: begin
        if (req[1])      next_owner = 3'b010;
        else if (req[2]) next_owner = 3'b100;
        else if (req[0]) next_owner = 3'b001;
      end
      3'b010: begin
        if (req[2])      next_owner = 3'b100;
        else if (req[0]) next_owner = 3'b001;
        else if (req[1]) next_owner = 3'b010;
      end
      default: begin
        if (req[0])      next_owner = 3'b001;
        else if (req[1]) next_owner = 3'b010;
        else if (req[2]) next_owner = 3'b100;
      end
    endcase
  end

  assign found = |next_owner;

endmodule

// File: rtl/mux_src_arbiter.sv
// Round-robin owner of the shared 3-source mux with a break-before-make gap.
// Optional forced release after MAX_HOLD grant cycles: define MUX_ARB_TIMEOUT_EN.
module mux_src_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SWITCH_GAP = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic               busy,
  output logic               preempt
);

  localparam int              GAP_W    = 2;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(SWITCH_GAP - 1);

  if (SWITCH_GAP < 1 || SWITCH_GAP > 3 || MAX_HOLD < 2) begin : g_param_check
    $error("mux_src_arbiter: SWITCH_GAP must be 1..3 and MAX_HOLD at least 2");
  end

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   owner_q, owner_d;
  logic [NUM_SRC-1:0]   last_q, last_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 rel;

  logic [NUM_SRC-1:0]   pick_req, pick_last, pick_owner;
  logic                 pick_found;

  logic [NUM_SRC-1:0]   grant_d;
  logic [1:0]           sel_d;
  logic                 valid_d, busy_d, preempt_d;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int              HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 force_rel;
`endif

  // While granted, the current owner is excluded so a release never re-picks it.
  always_comb begin
    pick_req  = req;
    pick_last = last_q;
    if (state_q == ST_GRANT) begin
      pick_req  = req & ~owner_q;
      pick_last = owner_q;
    end
  end

  rr_pick3 u_pick (
    .req        (pick_req),
    .last_owner (pick_last),
    .next_owner (pick_owner),
    .found      (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= 3'b100;
      gap_q     <= '0;
      grant     <= '0;
      sel       <= SEL_PARK;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      grant     <= grant_d;
      sel       <= sel_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      preempt   <= preempt_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gap_d   = gap_q;
    rel     = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    force_rel = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d = pick_owner;
          gap_d   = GAP_INIT;
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (!(|(req & owner_q))) begin
          if (pick_found) begin
            owner_d = pick_owner;
            gap_d   = GAP_INIT;
          end else begin
            owner_d = '0;
            state_d = ST_IDLE;
          end
        end else if (gap_q == '0) begin
          state_d = ST_GRANT;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_GRANT: begin
        rel = !(|(req & owner_q));
`ifdef MUX_ARB_TIMEOUT_EN
        // >= keeps a late competitor effective once the counter has saturated.
        if (!rel && pick_found && hold_q >= HOLD_LAST) begin
          rel       = 1'b1;
          force_rel = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
`endif
        if (rel) begin
          last_d = owner_q;
          if (pick_found) begin
            owner_d = pick_owner;
            gap_d   = GAP_INIT;
            state_d = ST_SWITCH;
          end else begin
            owner_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        owner_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    grant_d = (state_d == ST_GRANT) ? owner_d : '0;
    sel_d   = (state_d == ST_IDLE) ? SEL_PARK : sel_of(owner_d);
    valid_d = |grant_d;
    busy_d  = (state_d != ST_IDLE);
`ifdef MUX_ARB_TIMEOUT_EN
    preempt_d = force_rel;
`else
    preempt_d = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Scoreboard bench for mux_src_arbiter: expected grants queued by stimulus, popped by a monitor.
module tb_mux_src_arbiter;
  import mux_arb_pkg::*;

  localparam int G  = 1;
  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       out_valid, busy, preempt;

  mux_src_arbiter #(.SWITCH_GAP(G), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] g;
    logic [1:0] s;
    int         t;
  } exp_t;

  exp_t gq[$];
  int   pq[$];
  logic [2:0] prev_g = 3'b000;
  logic [1:0] prev_s = 2'd0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    tick(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      int   pt;
      chk("grant_onehot0", int'($countones(grant) <= 1), 1);
      chk("out_valid_eq_or_grant", out_valid, |grant);
      if (grant != 3'b000 && prev_g != 3'b000) begin
        chk("grant_stable", grant, prev_g);
        chk("sel_stable", sel, prev_s);
      end
      if (grant != 3'b000 && grant != prev_g) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %b at cycle %0d expected none", grant, cyc);
        end else begin
          e = gq.pop_front();
          chk("grant_owner", grant, e.g);
          chk("grant_sel", sel, e.s);
          chk("grant_cycle", cyc, e.t);
        end
      end
      if (preempt) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_preempt: got 1 at cycle %0d expected 0", cyc);
        end else begin
          pt = pq.pop_front();
          chk("preempt_cycle", cyc, pt);
        end
      end
      prev_g = grant;
      prev_s = sel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, g, t;
    logic [2:0] own [4];

    do_reset();
    mon_en = 1'b1;
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, SEL_PARK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_preempt", preempt, 0);

    // single requester latency
    c = cyc;
    req = 3'b001;
    gq.push_back('{g: 3'b001, s: SEL_SRC1, t: c + 1 + G});
    tick(1);
    chk("t1_sel", sel, SEL_SRC1);
    chk("t1_busy", busy, 1);
    chk("t1_gap_grant", grant, 0);
    tick_to(c + 1 + G + 3);
    req = 3'b000;
    tick(2);
    chk("t1_idle_sel", sel, SEL_PARK);
    chk("t1_idle_busy", busy, 0);

    // all three requesting, 4 grant cycles each
    do_reset();
    c = cyc;
    req = 3'b111;
    own[0] = 3'b001; own[1] = 3'b010; own[2] = 3'b100; own[3] = 3'b001;
    t = c + 1 + G;
    for (int k = 0; k < 4; k++)
      gq.push_back('{g: own[k], s: sel_of(own[k]), t: t + k * (4 + G)});
    for (int k = 0; k < 4; k++) begin
      tick_to(t + k * (4 + G) + 3);
      if (k < 3) begin
        req = 3'b111 & ~own[k];
        tick(1);
        req = 3'b111;
      end else begin
        req = 3'b000;
      end
    end
    tick(2 + G);
    chk("t2_idle_busy", busy, 0);

    // src2 releases with src1 and src3 pending
    do_reset();
    c = cyc;
    req = 3'b010;
    g = c + 1 + G;
    gq.push_back('{g: 3'b010, s: SEL_SRC2, t: g});
    tick_to(g);
    req = 3'b111;
    gq.push_back('{g: 3'b100, s: SEL_SRC3, t: g + 4 + G});
    tick_to(g + 3);
    req = 3'b101;
    tick_to(g + 4);
    chk("t3_sel_rr", sel, SEL_SRC3);
    chk("t3_gap_grant", grant, 0);
    g = g + 4 + G;
    gq.push_back('{g: 3'b001, s: SEL_SRC1, t: g + 4 + G});
    tick_to(g + 3);
    req = 3'b001;
    g = g + 4 + G;
    tick_to(g + 3);
    req = 3'b000;
    tick(2);

    // src1 drops during SWITCH, src2 takes over
    do_reset();
    c = cyc;
    req = 3'b011;
    tick(1);
    chk("t4_sel_first", sel, SEL_SRC1);
    req = 3'b010;
    gq.push_back('{g: 3'b010, s: SEL_SRC2, t: c + 2 + G});
    tick(1);
    chk("t4_sel_repick", sel, SEL_SRC2);
    chk("t4_gap_grant", grant, 0);
    tick_to(c + 2 + G + 2);
    req = 3'b000;
    tick(2);

    // reset while src3 is granted
    do_reset();
    c = cyc;
    req = 3'b100;
    g = c + 1 + G;
    gq.push_back('{g: 3'b100, s: SEL_SRC3, t: g});
    tick_to(g + 1);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_sel", sel, SEL_PARK);
    chk("t5_rst_busy", busy, 0);
    rst = 1'b0;
    req = 3'b111;
    c = cyc;
    gq.push_back('{g: 3'b001, s: SEL_SRC1, t: c + 1 + G});
    tick_to(c + 1 + G + 1);
    req = 3'b000;
    tick(2);

    // long hold by src1 with src2 waiting
    do_reset();
    c = cyc;
    req = 3'b011;
    g = c + 1 + G;
    gq.push_back('{g: 3'b001, s: SEL_SRC1, t: g});
`ifdef MUX_ARB_TIMEOUT_EN
    pq.push_back(g + MH);
    gq.push_back('{g: 3'b010, s: SEL_SRC2, t: g + MH + G});
    tick_to(g + MH);
    chk("t6_preempt_drop", grant, 0);
    req = 3'b010;
    tick_to(g + MH + G + 30);
    chk("t6_alone_holds", grant, 3'b010);
    req = 3'b000;
    tick(2);
`else
    tick_to(g + 20);
    chk("t6_no_preempt_grant", grant, 3'b001);
    chk("t6_no_preempt", preempt, 0);
    req = 3'b010;
    gq.push_back('{g: 3'b010, s: SEL_SRC2, t: g + 21 + G});
    tick_to(g + 21 + G + 3);
    req = 3'b000;
    tick(2);
`endif

    tick(5);
    chk("grant_queue_drained", gq.size(), 0);
    chk("preempt_queue_drained", pq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
